regfile_writeback_queue: RTL and testbench
==========================================

// Module: regfile_writeback_queue
// PURPOSE
//  Writeback-side producer for register_file: buffers result bundles from execute and drives
//  register_file write ports (write_addr0/1, write_data0/1, hi/lo data and valids).
//  In-order FIFO of DEPTH bundles; each bundle has <=2 GPR writes plus optional HI and LO.
//  Drains one bundle per unstalled cycle and exports a pending-write mask for issue hazard checks.
// PARAMETERS
//  DEPTH  4  queue entries; power of two, >=2
// PORTS
//  clk                       in   1   clock, all state on posedge
//  rst                       in   1   asynchronous, active-high reset
//  in_valid                  in   1   result bundle offered
//  in_ready                  out  1   bundle accepted on posedge when in_valid&in_ready
//  in_addr0/in_addr1         in   5   GPR destinations, slot 0 / slot 1
//  in_addr0_valid/1_valid    in   1   slot write enables
//  in_data0/in_data1         in   32  slot write data
//  in_hi_data/in_lo_data     in   32  HI / LO write data
//  in_hi_valid/in_lo_valid   in   1   HI / LO write enables
//  wb_stall                  in   1   1 = hold head, present no writes this cycle
//  write_addr0/write_addr1   out  5   to register_file
//  write_addr0_valid/1_valid out  1   to register_file
//  write_data0/write_data1   out  32  to register_file
//  write_hilo_hi_data/lo     out  32  to register_file
//  write_hilo_hi_data_valid  out  1   to register_file
//  write_hilo_lo_data_valid  out  1   to register_file
//  count                     out  $clog2(DEPTH)+1  occupied entries
//  empty                     out  1   count==0
//  pending_mask              out  32  bit r = queued write to GPR r
// BEHAVIOUR
//  Reset (async, immediate): rd/wr ptrs=0, count=0, all entry valid bits=0; all write_*_valid=0,
//   write addr/data outputs=0, empty=1, in_ready=1, pending_mask=0. Applies mid-drain: queued
//   bundles are discarded, no partial writes.
//  in_ready = (count != DEPTH); no acceptance when full, even if a pop occurs the same cycle.
//  Sanitising at push (stored form):
//   - slot with addr==0 -> its valid cleared (r0 never written).
//   - both slots valid, same addr -> slot0 valid cleared (slot1 is younger, wins).
//   - bundle with no valid after sanitising -> handshake completes, nothing enqueued, count unchanged.
//  pop = !empty & !wb_stall. Write outputs combinational from head entry; each valid = stored
//   valid & pop; addr/data = head fields when pop else 0.
//  Latency: bundle accepted at edge N with queue empty -> write ports valid during cycle N..N+1,
//   register_file commits at edge N+1. No input->output bypass in the same cycle.
//  Push & pop same edge: count unchanged, ptrs both advance. Ptrs wrap modulo DEPTH.
//  wb_stall while empty: no effect. Stall asserted: head held, all write valids 0.
//  pending_mask: OR over occupied entries of (1<<addr) for each valid slot; bit0 always 0; HI/LO not
//   included. Combinational from storage; a bundle being popped still shows in the mask that cycle.
//  count/empty registered with the pointers; in_ready derived from registered count.
// TESTING
//  1. Assert rst mid-cycle, no clk edge -> all write valids 0, count 0, empty 1, in_ready 1,
//     pending_mask 0.
//  2. Empty queue, push addr0=5 data0=32'hDEAD_BEEF, stall 0 -> next cycle write_addr0=5,
//     write_data0=DEADBEEF, valid 1 one cycle only; count 1->0; pending_mask[5] 1 for that cycle.
//  3. stall=1, push 4 bundles (addr0=1..4) -> count 4, in_ready 0, 5th bundle held on in_valid;
//     release stall -> addrs 1,2,3,4 in order on 4 consecutive cycles, then 5th accepted.
//  4. addr0=addr1=7, data0=8'h11, data1=8'h22 -> only write_addr1_valid, addr 7, data 32'h22;
//     addr0=0 with only slot0 valid -> bundle dropped, count unchanged, no write.
//  5. count=2, push (addr1=9, hi=32'h1234) while popping -> count stays 2; HI drained with
//     hilo_hi valid in order; pending_mask[9]=1 until that bundle pops.
//  6. count=3, stall=0, assert rst after first pop -> outputs 0 immediately; after release
//     queue empty, no stale writes appear.

Source files
------------

// File: rtl/regfile_writeback_queue_if.sv
// Bundle-side and register-file-side signals of the writeback queue.
//   master : execute/producer view. It drives the in_* bundle and wb_stall.
//            It observes the write ports and the status outputs.
//   slave  : queue view. It consumes the bundle and drives the write ports,
//            count, empty, in_ready and pending_mask.
interface regfile_writeback_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [4:0]       in_addr0;
  logic [4:0]       in_addr1;
  logic             in_addr0_valid;
  logic             in_addr1_valid;
  logic [31:0]      in_data0;
  logic [31:0]      in_data1;
  logic [31:0]      in_hi_data;
  logic [31:0]      in_lo_data;
  logic             in_hi_valid;
  logic             in_lo_valid;
  logic             wb_stall;

  logic [4:0]       write_addr0;
  logic [4:0]       write_addr1;
  logic             write_addr0_valid;
  logic             write_addr1_valid;
  logic [31:0]      write_data0;
  logic [31:0]      write_data1;
  logic [31:0]      write_hilo_hi_data;
  logic [31:0]      write_hilo_lo_data;
  logic             write_hilo_hi_data_valid;
  logic             write_hilo_lo_data_valid;
  logic [CNT_W-1:0] count;
  logic             empty;
  logic [31:0]      pending_mask;

  modport master (
    output in_valid, in_addr0, in_addr1, in_addr0_valid, in_addr1_valid,
           in_data0, in_data1, in_hi_data, in_lo_data, in_hi_valid, in_lo_valid,
           wb_stall,
    input  in_ready, write_addr0, write_addr1, write_addr0_valid, write_addr1_valid,
           write_data0, write_data1, write_hilo_hi_data, write_hilo_lo_data,
           write_hilo_hi_data_valid, write_hilo_lo_data_valid, count, empty,
           pending_mask
  );

  modport slave (
    input  in_valid, in_addr0, in_addr1, in_addr0_valid, in_addr1_valid,
           in_data0, in_data1, in_hi_data, in_lo_data, in_hi_valid, in_lo_valid,
           wb_stall,
    output in_ready, write_addr0, write_addr1, write_addr0_valid, write_addr1_valid,
           write_data0, write_data1, write_hilo_hi_data, write_hilo_lo_data,
           write_hilo_hi_data_valid, write_hilo_lo_data_valid, count, empty,
           pending_mask
  );
endinterface

// File: rtl/regfile_writeback_queue.sv
// In-order writeback queue between execute and the register file.
// Each bundle holds up to two GPR writes plus optional HI and LO writes.
// The queue drains one bundle per unstalled cycle.
// It exports a mask of GPRs that still have queued writes, for issue hazard checks.
// Ports:
//   clk  : clock; all state changes on the rising edge
//   rst  : asynchronous, active-high reset
//   bus  : regfile_writeback_queue_if.slave. It carries the bundle handshake and
//          wb_stall in, and the write ports, count, empty and pending_mask out.
module regfile_writeback_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  regfile_writeback_queue_if.slave   bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [4:0]  addr0;
    logic        addr0_valid;
    logic [31:0] data0;
    logic [4:0]  addr1;
    logic        addr1_valid;
    logic [31:0] data1;
    logic [31:0] hi_data;
    logic        hi_valid;
    logic [31:0] lo_data;
    logic        lo_valid;
  } bundle_t;

  // r0 is never written.
  // When both slots target the same GPR, slot1 is the younger result and wins.
  function automatic bundle_t sanitise(input bundle_t b);
    bundle_t s;
    s = b;
    s.addr1_valid = b.addr1_valid && (b.addr1 != 5'd0);
    s.addr0_valid = b.addr0_valid && (b.addr0 != 5'd0) &&
                    !(s.addr1_valid && (b.addr1 == b.addr0));
    return s;
  endfunction

  bundle_t          mem_q [DEPTH];
  bundle_t          mem_d [DEPTH];
  logic [DEPTH-1:0] occ_q, occ_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  bundle_t in_bundle;
  bundle_t in_clean;
  bundle_t head;
  logic    full;
  logic    empty;
  logic    has_write;
  logic    push;
  logic    pop;

  always_comb begin
    in_bundle.addr0       = bus.in_addr0;
    in_bundle.addr0_valid = bus.in_addr0_valid;
    in_bundle.data0       = bus.in_data0;
    in_bundle.addr1       = bus.in_addr1;
    in_bundle.addr1_valid = bus.in_addr1_valid;
    in_bundle.data1       = bus.in_data1;
    in_bundle.hi_data     = bus.in_hi_data;
    in_bundle.hi_valid    = bus.in_hi_valid;
    in_bundle.lo_data     = bus.in_lo_data;
    in_bundle.lo_valid    = bus.in_lo_valid;
  end

  assign in_clean  = sanitise(in_bundle);
  assign has_write = in_clean.addr0_valid | in_clean.addr1_valid |
                     in_clean.hi_valid    | in_clean.lo_valid;
  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  // A bundle with nothing left to write completes its handshake but is not stored.
  assign push      = bus.in_valid && !full && has_write;
  assign pop       = !empty && !bus.wb_stall;
  assign head      = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    occ_d    = occ_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_clean;
      occ_d[wr_ptr_q] = 1'b1;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      occ_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      occ_q    <= occ_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset; occupancy bits qualify every use of it.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Write ports are driven straight from the head entry and are gated by pop.
  always_comb begin
    bus.write_addr0_valid        = pop && head.addr0_valid;
    bus.write_addr1_valid        = pop && head.addr1_valid;
    bus.write_hilo_hi_data_valid = pop && head.hi_valid;
    bus.write_hilo_lo_data_valid = pop && head.lo_valid;
    bus.write_addr0              = pop ? head.addr0   : 5'd0;
    bus.write_addr1              = pop ? head.addr1   : 5'd0;
    bus.write_data0              = pop ? head.data0   : 32'd0;
    bus.write_data1              = pop ? head.data1   : 32'd0;
    bus.write_hilo_hi_data       = pop ? head.hi_data : 32'd0;
    bus.write_hilo_lo_data       = pop ? head.lo_data : 32'd0;
  end

  // The entry being popped this cycle still contributes to the mask.
  always_comb begin
    bus.pending_mask = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (occ_q[i]) begin
        if (mem_q[i].addr0_valid) bus.pending_mask[mem_q[i].addr0] = 1'b1;
        if (mem_q[i].addr1_valid) bus.pending_mask[mem_q[i].addr1] = 1'b1;
      end
    end
    bus.pending_mask[0] = 1'b0;
  end

  assign bus.count    = count_q;
  assign bus.empty    = empty;
  assign bus.in_ready = !full;
endmodule

// File: tb/tb_regfile_writeback_queue.sv
module tb_regfile_writeback_queue;
  localparam int DEPTH = 4;

  typedef struct {
    logic [4:0]  a0;
    logic        v0;
    logic [31:0] d0;
    logic [4:0]  a1;
    logic        v1;
    logic [31:0] d1;
    logic [31:0] hd;
    logic        hv;
    logic [31:0] ld;
    logic        lv;
  } wb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;
  wb_t  mq[$];

  regfile_writeback_queue_if #(.DEPTH(DEPTH)) bus ();

  regfile_writeback_queue #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Model: a queue of bundles that still carry a write after r0 and same-address filtering.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
    end else begin
      wb_t b;
      bit  accept;
      bit  drain;
      accept = bus.in_valid && (mq.size() < DEPTH);
      drain  = (mq.size() > 0) && !bus.wb_stall;
      b.a0 = bus.in_addr0; b.d0 = bus.in_data0;
      b.a1 = bus.in_addr1; b.d1 = bus.in_data1;
      b.hd = bus.in_hi_data; b.hv = bus.in_hi_valid;
      b.ld = bus.in_lo_data; b.lv = bus.in_lo_valid;
      b.v1 = bus.in_addr1_valid && (bus.in_addr1 != 0);
      b.v0 = bus.in_addr0_valid && (bus.in_addr0 != 0) && !(b.v1 && bus.in_addr1 == bus.in_addr0);
      if (drain) void'(mq.pop_front());
      if (accept && (b.v0 || b.v1 || b.hv || b.lv)) mq.push_back(b);
    end
  end

  // Compare process: every negedge, all outputs against the model.
  always @(negedge clk) begin
    logic [31:0] m;
    bit          go;
    wb_t         h;
    m  = 0;
    go = (mq.size() > 0) && !bus.wb_stall;
    foreach (mq[k]) begin
      if (mq[k].v0) m |= 32'd1 << mq[k].a0;
      if (mq[k].v1) m |= 32'd1 << mq[k].a1;
    end
    m[0] = 1'b0;
    if (go) h = mq[0];
    else begin
      h.a0 = 0; h.v0 = 0; h.d0 = 0; h.a1 = 0; h.v1 = 0; h.d1 = 0;
      h.hd = 0; h.hv = 0; h.ld = 0; h.lv = 0;
    end
    chk("m_count",    32'(bus.count),  32'(mq.size()));
    chk("m_empty",    32'(bus.empty),  32'(mq.size() == 0));
    chk("m_in_ready", 32'(bus.in_ready), 32'(mq.size() != DEPTH));
    chk("m_mask",     bus.pending_mask, m);
    chk("m_v0",       32'(bus.write_addr0_valid), 32'(h.v0));
    chk("m_v1",       32'(bus.write_addr1_valid), 32'(h.v1));
    chk("m_hv",       32'(bus.write_hilo_hi_data_valid), 32'(h.hv));
    chk("m_lv",       32'(bus.write_hilo_lo_data_valid), 32'(h.lv));
    chk("m_a0",       32'(bus.write_addr0), 32'(h.a0));
    chk("m_a1",       32'(bus.write_addr1), 32'(h.a1));
    chk("m_d0",       bus.write_data0, h.d0);
    chk("m_d1",       bus.write_data1, h.d1);
    chk("m_hd",       bus.write_hilo_hi_data, h.hd);
    chk("m_ld",       bus.write_hilo_lo_data, h.ld);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] a0, input logic v0, input logic [31:0] d0,
                       input logic [4:0] a1, input logic v1, input logic [31:0] d1,
                       input logic hv, input logic [31:0] hd,
                       input logic lv, input logic [31:0] ld);
    bus.in_valid = 1'b1;
    bus.in_addr0 = a0; bus.in_addr0_valid = v0; bus.in_data0 = d0;
    bus.in_addr1 = a1; bus.in_addr1_valid = v1; bus.in_data1 = d1;
    bus.in_hi_valid = hv; bus.in_hi_data = hd;
    bus.in_lo_valid = lv; bus.in_lo_data = ld;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.in_valid = 1'b0;
  endtask

  task automatic zero_outputs(input string tag);
    chk({tag, "_v0"},    32'(bus.write_addr0_valid), 0);
    chk({tag, "_v1"},    32'(bus.write_addr1_valid), 0);
    chk({tag, "_hv"},    32'(bus.write_hilo_hi_data_valid), 0);
    chk({tag, "_lv"},    32'(bus.write_hilo_lo_data_valid), 0);
    chk({tag, "_a0"},    32'(bus.write_addr0), 0);
    chk({tag, "_d0"},    bus.write_data0, 0);
    chk({tag, "_count"}, 32'(bus.count), 0);
    chk({tag, "_empty"}, 32'(bus.empty), 1);
    chk({tag, "_rdy"},   32'(bus.in_ready), 1);
    chk({tag, "_mask"},  bus.pending_mask, 0);
  endtask

  initial begin
    bus.wb_stall = 1'b0;
    idle();
    repeat (2) cyc();
    rst = 1'b0;
    #1;
    zero_outputs("reset");

    // Single push, drains the following cycle.
    cyc();
    drive(5, 1, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    idle();
    #1;
    chk("t2_v0",    32'(bus.write_addr0_valid), 1);
    chk("t2_a0",    32'(bus.write_addr0), 5);
    chk("t2_d0",    bus.write_data0, 32'hDEAD_BEEF);
    chk("t2_count", 32'(bus.count), 1);
    chk("t2_mask5", 32'(bus.pending_mask[5]), 1);
    cyc();
    #1;
    chk("t2_v0_off", 32'(bus.write_addr0_valid), 0);
    chk("t2_count0", 32'(bus.count), 0);

    // Fill under stall, hold a fifth bundle, then drain in order.
    cyc();
    bus.wb_stall = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(5'(i), 1, 32'h100 + i, 0, 0, 0, 0, 0, 0, 0);
      cyc();
    end
    drive(5, 1, 32'h105, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("t3_full_count", 32'(bus.count), 4);
    chk("t3_full_rdy",   32'(bus.in_ready), 0);
    chk("t3_mask",       bus.pending_mask, 32'h0000_001E);
    cyc();
    cyc();
    chk("t3_held_count", 32'(bus.count), 4);
    chk("t3_stall_v0",   32'(bus.write_addr0_valid), 0);
    bus.wb_stall = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      #1;
      chk("t3_order_a0", 32'(bus.write_addr0), i);
      chk("t3_order_v0", 32'(bus.write_addr0_valid), 1);
      cyc();
      if (i == 2) idle();
    end
    chk("t3_drained", 32'(bus.empty), 1);

    // Same-address slots: slot1 wins. r0-only bundle is dropped.
    drive(7, 1, 32'h11, 7, 1, 32'h22, 0, 0, 0, 0);
    cyc();
    idle();
    #1;
    chk("t4_v0", 32'(bus.write_addr0_valid), 0);
    chk("t4_v1", 32'(bus.write_addr1_valid), 1);
    chk("t4_a1", 32'(bus.write_addr1), 7);
    chk("t4_d1", bus.write_data1, 32'h22);
    cyc();
    drive(0, 1, 32'h33, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("t4_r0_rdy", 32'(bus.in_ready), 1);
    cyc();
    idle();
    #1;
    chk("t4_r0_count", 32'(bus.count), 0);
    chk("t4_r0_v0",    32'(bus.write_addr0_valid), 0);

    // Push during pop at count 2, with a HI write.
    cyc();
    bus.wb_stall = 1'b1;
    drive(10, 1, 32'hA, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    drive(11, 1, 32'hB, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    bus.wb_stall = 1'b0;
    drive(0, 0, 0, 9, 1, 32'h99, 1, 32'h1234, 0, 0);
    cyc();
    idle();
    #1;
    chk("t5_count", 32'(bus.count), 2);
    chk("t5_mask9", 32'(bus.pending_mask[9]), 1);
    chk("t5_head",  32'(bus.write_addr0), 11);
    cyc();
    #1;
    chk("t5_hv",    32'(bus.write_hilo_hi_data_valid), 1);
    chk("t5_hd",    bus.write_hilo_hi_data, 32'h1234);
    chk("t5_a1",    32'(bus.write_addr1), 9);
    chk("t5_mask9b", 32'(bus.pending_mask[9]), 1);
    cyc();
    #1;
    chk("t5_mask_clear", bus.pending_mask, 0);

    // Asynchronous reset mid-drain with no clock edge.
    cyc();
    bus.wb_stall = 1'b1;
    for (int i = 12; i <= 14; i++) begin
      drive(5'(i), 1, 32'h200 + i, 0, 0, 0, 0, 0, 0, 0);
      cyc();
    end
    idle();
    bus.wb_stall = 1'b0;
    #1;
    chk("t6_first", 32'(bus.write_addr0), 12);
    cyc();
    #1;
    chk("t6_second", 32'(bus.write_addr0), 13);
    chk("t6_count",  32'(bus.count), 2);
    #1;
    rst = 1'b1;
    #1;
    zero_outputs("async_rst");
    cyc();
    rst = 1'b0;
    #1;
    zero_outputs("post_rst");
    repeat (3) cyc();
    chk("t6_no_stale", 32'(bus.write_addr0_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
